// File: rtl/accel_feeder_if.sv
// Handshake bundle between the operand feeder, its upstream source,
// the series-evaluation core and the downstream result consumer.
interface accel_feeder_if #(
    parameter int XW = 16,
    parameter int RW = 16
);
    logic          in_valid;
    logic [XW-1:0] in_data;
    logic          in_ready;
    logic          core_start;
    logic [XW-1:0] core_x;
    logic          core_ready;
    logic [RW-1:0] core_result;
    logic          out_valid;
    logic [RW-1:0] out_data;
    logic          out_ack;
    logic          busy;
    logic [7:0]    done_count;

    // Feeder side
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output core_start,
        output core_x,
        input  core_ready,
        input  core_result,
        output out_valid,
        output out_data,
        input  out_ack,
        output busy,
        output done_count
    );

    // Environment side: upstream source, core and result consumer
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  core_start,
        input  core_x,
        output core_ready,
        output core_result,
        input  out_valid,
        input  out_data,
        output out_ack,
        input  busy,
        input  done_count
    );
endinterface

// File: rtl/accel_feeder.sv
// Operand feeder: buffers operands in a small FIFO, launches one core job
// per operand with a single-cycle start pulse, waits for the core's
// ready low/high cycle and captures each result into a one-entry output
// register that the downstream side acknowledges.
module accel_feeder #(
    parameter int XW    = 16,
    parameter int RW    = 16,
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic           clock,
    input  logic           reset,
    accel_feeder_if.master bus
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        CAPTURE   = 3'd4
    } state_t;

    state_t        state_r;
    logic [XW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [XW-1:0] x_r;
    logic          core_start_r;
    logic          out_valid_r;
    logic [RW-1:0] out_data_r;
    logic [7:0]    done_count_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          launch_ok_s;
    logic          capture_s;

    // Occupancy flags, handshake qualifiers and launch/capture decisions
    always_comb begin
        full_s      = (count_r == CNT_FULL);
        empty_s     = (count_r == CNT_ZERO);
        push_s      = bus.in_valid & ~full_s;
        // A new job may start only if the result register is free or is
        // being freed on this very edge, so an ack never costs a bubble.
        launch_ok_s = ~empty_s & bus.core_ready & (~out_valid_r | bus.out_ack);
        if (state_r == IDLE) begin
            pop_s = launch_ok_s;
        end else begin
            pop_s = 1'b0;
        end
        if (state_r == WAIT_HIGH) begin
            capture_s = bus.core_ready;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Operand storage; contents are don't-care while the slot is empty
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Job sequencer with its registered start pulse, operand and result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            x_r          <= '0;
            core_start_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            done_count_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_ok_s) begin
                        x_r          <= mem_r[rd_ptr_r];
                        core_start_r <= 1'b1;
                        state_r      <= START;
                    end else begin
                        core_start_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                START: begin
                    core_start_r <= 1'b0;
                    state_r      <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    core_start_r <= 1'b0;
                    // The core acknowledges the start by dropping ready
                    if (!bus.core_ready) begin
                        state_r <= WAIT_HIGH;
                    end else begin
                        state_r <= WAIT_LOW;
                    end
                end
                WAIT_HIGH: begin
                    core_start_r <= 1'b0;
                    if (bus.core_ready) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                CAPTURE: begin
                    core_start_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    core_start_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase

            // A capture outranks a same-edge acknowledge
            if (capture_s) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= bus.core_result;
                done_count_r <= done_count_r + 8'd1;
            end else if (bus.out_ack && out_valid_r) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ~full_s;
    assign bus.core_start = core_start_r;
    assign bus.core_x     = x_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.busy       = (state_r != IDLE);
    assign bus.done_count = done_count_r;
endmodule

// File: tb/tb_accel_feeder.sv
// Directed bench for accel_feeder with a behavioural core model whose
// ready-low duration is programmable per scenario.
module tb_accel_feeder;
    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    accel_feeder_if #(.XW(16), .RW(16)) bus ();

    accel_feeder #(.XW(16), .RW(16), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Core model: result is byte-swapped operand plus 0x0011
    function automatic logic [15:0] core_fn(input logic [15:0] x);
        return {x[7:0], x[15:8]} + 16'h0011;
    endfunction

    logic        core_rdy_m = 1'b1;
    logic [15:0] core_res_m = 16'h0000;
    logic [15:0] core_lat_m = 16'h0000;
    int          core_cnt   = 0;
    int          core_delay = 2;
    int          start_cnt  = 0;

    assign bus.core_ready  = core_rdy_m;
    assign bus.core_result = core_res_m;

    // Core drops ready for core_delay cycles after each start, then presents its result
    always @(posedge clock) begin
        if (bus.core_start && core_rdy_m) begin
            core_rdy_m <= 1'b0;
            core_cnt   <= core_delay;
            core_lat_m <= bus.core_x;
        end else if (!core_rdy_m) begin
            if (core_cnt <= 1) begin
                core_rdy_m <= 1'b1;
                core_res_m <= core_fn(core_lat_m);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Count start pulses
    always @(posedge clock) begin
        if (bus.core_start) begin
            start_cnt <= start_cnt + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one operand and hold it until accepted
    task automatic push(input logic [15:0] x);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (waited >= 200) begin
            total++;
            bad++;
            $display("FAIL push_timeout: in_ready still %b, required 1", bus.in_ready);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
        total++; if (bus.done_count !== 8'd0) begin bad++; $display("FAIL rst_done_count: got %0d want 0", bus.done_count); end
        total++; if (bus.core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start: got %b want 0", bus.core_start); end
        total++; if (bus.core_x !== 16'h0000) begin bad++; $display("FAIL rst_core_x: got %h want 0000", bus.core_x); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single;
        int s0;
        int n;
        int xbad;
        core_delay = 40;
        s0   = start_cnt;
        xbad = 0;
        n    = 0;
        push(16'h0100);
        while (!bus.out_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.busy && bus.core_x !== 16'h0100) xbad++;
        end
        total++; if (n !== 43) begin bad++; $display("FAIL single_latency: got %0d cycles want 43", n); end
        total++; if (xbad !== 0) begin bad++; $display("FAIL core_x_stable: %0d unstable cycles want 0", xbad); end
        total++; if (bus.out_data !== 16'h0012) begin bad++; $display("FAIL single_result: got %h want 0012", bus.out_data); end
        total++; if (bus.done_count !== 8'd1) begin bad++; $display("FAIL single_done_count: got %0d want 1", bus.done_count); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
        tick(1);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy %b want 0", bus.busy); end
    endtask

    // Result left unacknowledged fills the FIFO, then an ack releases the queue
    task automatic test_fifo_hold_ack;
        logic [15:0] ops [5];
        logic [15:0] exp [5];
        int s0;
        int n;
        ops[0] = 16'h0001; exp[0] = 16'h0111;
        ops[1] = 16'h0002; exp[1] = 16'h0211;
        ops[2] = 16'h0003; exp[2] = 16'h0311;
        ops[3] = 16'h00FF; exp[3] = 16'hFF11;
        ops[4] = 16'h1234; exp[4] = 16'h3423;
        core_delay = 2;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) push(ops[i]);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold_busy: got %b want 0", bus.busy); end
        bus.in_valid = 1'b1;
        bus.in_data  = ops[4];
        tick(3);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_hold_in_ready: got %b want 0", bus.in_ready); end
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL hold_no_start: got %0d starts want 0", start_cnt - s0); end
        total++; if (bus.out_data !== 16'h0012) begin bad++; $display("FAIL hold_out_data: got %h want 0012", bus.out_data); end
        bus.out_ack = 1'b1;
        tick(1);
        bus.out_ack = 1'b0;
        total++; if (bus.core_start !== 1'b1) begin bad++; $display("FAIL ack_start_no_bubble: got %b want 1", bus.core_start); end
        total++; if (bus.core_x !== ops[0]) begin bad++; $display("FAIL ack_core_x: got %h want %h", bus.core_x, ops[0]); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ack_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL pop_in_ready: got %b want 1", bus.in_ready); end
        tick(1);
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fifth_pushed: in_ready %b want 0", bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!bus.out_valid && n < 100) begin
                tick(1);
                n++;
            end
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin
                bad++; $display("FAIL order_result%0d: valid %b data %h want 1 %h", k, bus.out_valid, bus.out_data, exp[k]);
            end
            bus.out_ack = 1'b1;
            tick(1);
            bus.out_ack = 1'b0;
        end
        tick(2);
        total++; if (bus.done_count !== 8'd6) begin bad++; $display("FAIL order_done_count: got %0d want 6", bus.done_count); end
        total++; if (start_cnt - s0 !== 5) begin bad++; $display("FAIL order_starts: got %0d want 5", start_cnt - s0); end
    endtask

    task automatic test_reset_mid;
        int s0;
        core_delay = 20;
        s0 = start_cnt;
        push(16'h0AAA);
        push(16'h0BBB);
        push(16'h0CCC);
        push(16'h0DDD);
        tick(5);
        total++; if (bus.busy !== 1'b1 || start_cnt - s0 !== 1) begin
            bad++; $display("FAIL mid_job_running: busy %b starts %0d want 1 1", bus.busy, start_cnt - s0);
        end
        reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.done_count !== 8'd0) begin bad++; $display("FAIL mid_rst_done_count: got %0d want 0", bus.done_count); end
        total++; if (bus.core_x !== 16'h0000) begin bad++; $display("FAIL mid_rst_core_x: got %h want 0000", bus.core_x); end
        tick(1);
        reset = 1'b0;
        tick(40);
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL mid_discard: got %0d starts want 1", start_cnt - s0); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_capture: out_valid %b want 0", bus.out_valid); end
        total++; if (bus.done_count !== 8'd0) begin bad++; $display("FAIL mid_done_count: got %0d want 0", bus.done_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap;
        int s0;
        int n;
        logic [15:0] x;
        core_delay  = 1;
        s0          = start_cnt;
        bus.out_ack = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            x = 16'(i);
            push(x);
        end
        n = 0;
        while ((start_cnt - s0 < 257 || bus.busy) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(2);
        bus.out_ack = 1'b0;
        total++; if (start_cnt - s0 !== 257) begin bad++; $display("FAIL wrap_starts: got %0d want 257", start_cnt - s0); end
        total++; if (bus.done_count !== 8'd1) begin bad++; $display("FAIL wrap_done_count: got %0d want 1", bus.done_count); end
        total++; if (bus.out_data !== 16'h0112) begin bad++; $display("FAIL wrap_last_result: got %h want 0112", bus.out_data); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.out_ack  = 1'b0;
        test_reset();
        test_single();
        test_fifo_hold_ack();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_feeder.md
ACCEL_FEEDER -- requirements
Module: accel_feeder

Interface
REQ-001 Parameter XW, default 16, width of an operand x.
REQ-002 Parameter RW, default 16, width of a core result.
REQ-003 Parameter DEPTH, default 4, operand FIFO depth; power of 2, at least 2.
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream operand valid.
REQ-007 in_data  input  XW  upstream operand.
REQ-008 in_ready  output  1  FIFO can accept an operand.
REQ-009 core_start  output  1  start request to the series-evaluation core.
REQ-010 core_x  output  XW  operand presented to the core.
REQ-011 core_ready  input  1  core idle/done flag: high in idle, low while computing.
REQ-012 core_result  input  RW  core result, valid when core_ready returns high.
REQ-013 out_valid  output  1  result register holds an unconsumed result.
REQ-014 out_data  output  RW  result register.
REQ-015 out_ack  input  1  downstream consumes the result when high with out_valid.
REQ-016 busy  output  1  high in any FSM state other than IDLE.
REQ-017 done_count  output  8  number of results captured, modulo 256.

Function
REQ-018 Push occurs on a rising clock edge when in_valid and in_ready are both high; in_ready SHALL equal not-full.
REQ-019 FIFO SHALL be first-in first-out; occupancy SHALL never exceed DEPTH or fall below 0; pointers wrap modulo DEPTH.
REQ-020 FSM states SHALL be IDLE, START, WAIT_LOW, WAIT_HIGH and CAPTURE.
REQ-021 IDLE -> START when FIFO non-empty, core_ready high, and (out_valid low or out_ack high); otherwise remain.
REQ-022 On the IDLE -> START edge, the FIFO head SHALL be loaded into x_reg and popped.
REQ-023 Push and pop on the same edge SHALL both take effect, with occupancy unchanged.
REQ-024 START lasts exactly one cycle, with core_start high; then -> WAIT_LOW.
REQ-025 core_start SHALL be high only in START; one pulse per operand.
REQ-026 core_x SHALL equal x_reg and SHALL remain stable from START until the FSM returns to IDLE.
REQ-027 WAIT_LOW -> WAIT_HIGH when core_ready is low; otherwise remain.
REQ-028 WAIT_HIGH -> CAPTURE when core_ready is high; otherwise remain.
REQ-029 On entry to CAPTURE, out_data SHALL load core_result, out_valid SHALL set, and done_count SHALL increment, wrapping 255 -> 0.
REQ-030 CAPTURE lasts one cycle, then -> IDLE.
REQ-031 out_valid SHALL clear on an edge where out_ack is high; out_data SHALL hold while out_valid is high and no ack occurs.
REQ-032 out_ack while out_valid is low SHALL be ignored.
REQ-033 If set (CAPTURE entry) and clear (out_ack) fall on the same edge, set SHALL win and the new result SHALL be loaded.
REQ-034 Minimum latency, push to out_valid: 1 cycle to non-empty, plus 1 (START), plus the core duration, plus 1 (capture).
REQ-035 In any non-IDLE state, FIFO pushes SHALL continue normally.

Reset
REQ-036 Reset SHALL asynchronously force the FSM to IDLE and the FIFO to empty (pointers 0).
REQ-037 Reset SHALL force x_reg = 0, out_data = 0, out_valid = 0, done_count = 0 and core_start = 0.
REQ-038 While reset is held, in_ready SHALL be 1 and busy SHALL be 0.
REQ-039 Reset mid-job SHALL discard the in-flight operand and all buffered operands; no result is delivered for them.

Verification
REQ-040 Single push x = 0x0100, core model drops ready for 40 cycles -> exactly one core_start pulse; core_x = 0x0100 throughout the job; out_valid rises with out_data = model result; done_count = 1.
REQ-041 Push 5 operands back-to-back, DEPTH = 4, no pops -> in_ready low after the 4th push; the 5th is held until the first START; results emerge in push order.
REQ-042 Hold out_ack = 0 after the first result, 2 operands queued -> no second core_start until out_ack; out_data unchanged meanwhile.
REQ-043 out_ack in the same cycle a new job is allowed to start -> START is taken that cycle; no bubble.
REQ-044 Assert reset during WAIT_HIGH with 3 operands queued -> busy = 0, out_valid = 0, in_ready = 1, done_count = 0; the later core_ready rise produces no capture.
REQ-045 Run 257 jobs -> done_count reads 1.
